// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 64x64->128 unsigned shift-add multiplier that borrows the
// execute-stage ALU for its additions, one ALU operation per clock.
// Optional build macro SIGNED_MUL_EN adds a mul_signed port plus the NEG_OPS
// (operand magnitude) and FIX (result sign) states for signed multiplies.
module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
`ifdef SIGNED_MUL_EN
  input  logic               mul_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               prod_zero,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [4:0]         alu_fs,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_f,
  input  logic               alu_cout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DONE  = 3'd2;
`ifdef SIGNED_MUL_EN
  localparam logic [2:0] S_NEG_A = 3'd3;  // first NEG_OPS cycle: multiplicand
  localparam logic [2:0] S_NEG_B = 3'd4;  // second NEG_OPS cycle: multiplier
  localparam logic [2:0] S_FIX   = 3'd5;
  localparam logic [4:0] FS_NEG_B = 5'b01001;  // 0 + (-B)
`endif
  localparam logic [4:0] FS_ZERO = 5'b11000;
  localparam logic [4:0] FS_ADD  = 5'b01000;

  logic [2:0]         state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mc;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] step_next;
  logic               last_step;
`ifdef SIGNED_MUL_EN
  logic               signed_op;
  logic               neg_result;
`endif

  // One shift-add step: ALU sum (with carry) becomes the new upper half while
  // the whole {acc,lo} pair moves right by one, retiring the multiplier LSB.
  assign step_next = {alu_cout, alu_f, lo[WIDTH-1:1]};
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // Busy covers every state that is still working on an accepted request.
`ifdef SIGNED_MUL_EN
  assign busy = (state == S_RUN) || (state == S_NEG_A) || (state == S_NEG_B) || (state == S_FIX);
`else
  assign busy = (state == S_RUN);
`endif

  // ALU request for the current state; idle states issue the zero op.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    alu_a   = '0;
    alu_b   = '0;
    alu_fs  = FS_ZERO;
    alu_cin = 1'b0;
    case (state)
      S_RUN: begin
        alu_a  = acc;
        alu_b  = lo[0] ? mc : '0;
        alu_fs = FS_ADD;
      end
`ifdef SIGNED_MUL_EN
      S_NEG_A: begin
        alu_b  = mc;
        alu_fs = FS_NEG_B;
      end
      S_NEG_B: begin
        alu_b  = lo;
        alu_fs = FS_NEG_B;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer state, datapath registers and the registered result/done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      lo        <= '0;
      mc        <= '0;
      cnt       <= '0;
      product   <= '0;
      prod_zero <= 1'b0;
      done      <= 1'b0;
`ifdef SIGNED_MUL_EN
      signed_op  <= 1'b0;
      neg_result <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, like real flops.
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            mc  <= mcand;
            lo  <= mplier;
            acc <= '0;
            cnt <= '0;
`ifdef SIGNED_MUL_EN
            signed_op  <= mul_signed;
            neg_result <= mul_signed & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
            state      <= mul_signed ? S_NEG_A : S_RUN;
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          {acc, lo} <= step_next;
          // Hold the counter on the final step instead of letting it wrap.
          cnt <= last_step ? cnt : cnt + 1'b1;
          if (last_step) begin
`ifdef SIGNED_MUL_EN
            if (signed_op) begin
              state <= S_FIX;
            end else begin
              product   <= step_next;
              prod_zero <= (step_next == '0);
              state     <= S_DONE;
            end
`else
            product   <= step_next;
            prod_zero <= (step_next == '0);
            state     <= S_DONE;
`endif
          end
        end
        S_DONE: state <= S_IDLE;
`ifdef SIGNED_MUL_EN
        S_NEG_A: begin
          mc    <= mc[WIDTH-1] ? alu_f : mc;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          lo    <= lo[WIDTH-1] ? alu_f : lo;
          state <= S_RUN;
        end
        S_FIX: begin
          product   <= neg_result ? -{acc, lo} : {acc, lo};
          prod_zero <= ({acc, lo} == '0);
          state     <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: pairs the multiplier with a behavioural ALU and checks
// every cycle against a request-level model (product = a*b, fixed latency).
`timescale 1ns/1ps
module tb_alu_mul_sequencer;
  localparam int W = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
`ifdef SIGNED_MUL_EN
  logic           mul_signed = 1'b0;
`endif
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           prod_zero;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [4:0]     alu_fs;
  logic           alu_cin;
  logic [W-1:0]   alu_f;
  logic           alu_cout;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mcand(mcand), .mplier(mplier),
`ifdef SIGNED_MUL_EN
    .mul_signed(mul_signed),
`endif
    .busy(busy), .done(done), .product(product), .prod_zero(prod_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout)
  );

  always #5 clock = ~clock;

  // Behavioural ALU from the FS map.
  logic [W-1:0] ea, eb;
  logic [W:0]   esum;
  always_comb begin
    ea       = alu_fs[1] ? -alu_a : alu_a;
    eb       = alu_fs[0] ? -alu_b : alu_b;
    esum     = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, alu_cin};
    alu_cout = 1'b0;
    case (alu_fs[4:2])
      3'b000: alu_f = ea & eb;
      3'b001: alu_f = ea | eb;
      3'b010: begin alu_f = esum[W-1:0]; alu_cout = esum[W]; end
      3'b011: alu_f = ea ^ eb;
      3'b100: alu_f = ea >> 1;
      3'b101: alu_f = ea << 1;
      3'b110: alu_f = '0;
      default: alu_f = '1;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Request-level model: an accepted start at edge k yields a*b, visible in
  // product from edge k+lat-1 and pulsed on done after edge k+lat.
  int           cyc = 0;
  bit           m_active = 1'b0;
  int           m_k = 0;
  int           m_lat = 65;
  bit           m_sgn = 1'b0;
  logic [127:0] m_next = '0;
  logic [127:0] m_prod = '0;
  bit           m_pz = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_prod   = '0;
      m_pz     = 1'b0;
    end else begin
      cyc++;
      if (m_active && cyc == m_k + m_lat - 1) begin
        m_prod = m_next;
        m_pz   = (m_next == '0);
      end
      if (m_active && cyc > m_k + m_lat) m_active = 1'b0;
      if (!m_active && start) begin
        m_active = 1'b1;
        m_k      = cyc;
        m_lat    = 65;
        m_sgn    = 1'b0;
        m_next   = {64'd0, mcand} * {64'd0, mplier};
`ifdef SIGNED_MUL_EN
        if (mul_signed) begin
          m_sgn  = 1'b1;
          m_lat  = 68;
          m_next = 128'($signed({{64{mcand[63]}}, mcand}) * $signed({{64{mplier[63]}}, mplier}));
        end
`endif
      end
    end
  end

  // Per-cycle comparison of all DUT outputs against the model.
  bit         in_run;
  bit         exp_done;
  logic [4:0] exp_fs;
  always @(negedge clock) begin
    in_run   = m_active && cyc >= m_k && cyc < m_k + m_lat - 1;
    exp_done = m_active && cyc == m_k + m_lat;
    exp_fs   = 5'b11000;
    if (in_run) begin
      exp_fs = 5'b01000;
      if (m_sgn && cyc < m_k + 2) exp_fs = 5'b01001;
      if (m_sgn && cyc == m_k + 66) exp_fs = 5'b11000;
    end
    check("busy", 128'(busy), 128'(in_run));
    check("done", 128'(done), 128'(exp_done));
    check("product", product, m_prod);
    check("prod_zero", 128'(prod_zero), 128'(m_pz));
    check("alu_cin", 128'(alu_cin), 128'd0);
    check("alu_fs", 128'(alu_fs), 128'(exp_fs));
    if (!in_run) begin
      check("alu_a idle", 128'(alu_a), 128'd0);
      check("alu_b idle", 128'(alu_b), 128'd0);
    end
  end

  // One multiply: start held for `hold` edges, operands scrambled after that.
  task automatic mul_once(input logic [63:0] a, input logic [63:0] b, input int hold,
                          input int exp_lat, input logic [127:0] exp_p, input string tag);
    int n;
    bit seen;
    @(negedge clock);
    start = 1'b1; mcand = a; mplier = b;
    @(posedge clock);
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n >= hold) begin
        start  = 1'b0;
        mcand  = {$urandom, $urandom};
        mplier = {$urandom, $urandom};
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, " latency"}, 128'(n), 128'(exp_lat));
    check({tag, " product"}, product, exp_p);
    check({tag, " prod_zero"}, 128'(prod_zero), 128'(exp_p == '0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, extra, busy_cnt;
    logic [127:0] p4;
    logic [63:0] ra, rb;
    #1 reset = 1'b1;
    #2;
    check("reset busy", 128'(busy), 128'd0);
    check("reset done", 128'(done), 128'd0);
    check("reset product", product, 128'd0);
    check("reset prod_zero", 128'(prod_zero), 128'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    mul_once(64'd3, 64'd5, 1, 65, 128'd15, "t1");
    check("model t1", m_prod, 128'd15);
    mul_once('1, '1, 1, 65, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "t2");
    check("model t2", m_prod, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    mul_once(64'h1234, 64'd0, 1, 65, 128'd0, "t3");

    // Start held high through RUN and DONE: one restart, two done pulses.
    @(negedge clock);
    start = 1'b1; mcand = 64'd7; mplier = 64'd2;
    @(posedge clock);
    first = 0; second = 0; extra = 0; busy_cnt = 0; p4 = '0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (n == 80) start = 1'b0;
      if (n < 64 && busy) busy_cnt++;
      if (done) begin
        if (first == 0) begin first = n; p4 = product; end
        else if (second == 0) second = n;
        else extra++;
      end
    end
    check("t4 busy cycles", 128'(busy_cnt), 128'd63);
    check("t4 first done", 128'(first), 128'd65);
    check("t4 first product", p4, 128'd14);
    check("t4 second done", 128'(second), 128'd131);
    check("t4 extra done", 128'(extra), 128'd0);

    // Reset in the middle of RUN.
    @(negedge clock);
    start = 1'b1; mcand = 64'd9; mplier = 64'd11;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (30) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("t5 busy", 128'(busy), 128'd0);
    check("t5 done", 128'(done), 128'd0);
    check("t5 product", product, 128'd0);
    check("t5 prod_zero", 128'(prod_zero), 128'd0);
    @(negedge clock);
    reset = 1'b0;
    mul_once(64'd3, 64'd5, 1, 65, 128'd15, "t5 restart");

    // Randomized operands, hold lengths and gaps.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = '1;
        2: ra = 64'd1;
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: rb = 64'h8000_0000_0000_0000;
        default: rb = {$urandom, $urandom};
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clock);
      mul_once(ra, rb, $urandom_range(1, 3), 65, {64'd0, ra} * {64'd0, rb}, "rand");
    end

`ifdef SIGNED_MUL_EN
    mul_signed = 1'b1;
    mul_once(-64'sd3, 64'd5, 1, 68, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, "t6");
    mul_once(-64'sd7, -64'sd6, 1, 68, 128'd42, "t6 neg*neg");
    mul_signed = 1'b0;
    mul_once(64'd3, 64'd5, 1, 65, 128'd15, "t6 unsigned");
`endif

    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
